// File: rtl/wheel_state_buffer.sv
// wheel_state_buffer
//
// Holds the committed soft-body wheel state (node positions and velocities)
// and sequences the physics update stage: one begin pulse per step,
// STEPS_PER_FRAME steps per frame tick. The stage's streamed results are
// captured into shadow arrays and copied to the committed arrays only after
// the step's result strobe, so the committed arrays (which the stage reads as
// its inputs) never change mid-step.
//
// Ports
//   clk_in, rst_in              clock, asynchronous active-high reset
//   init_valid_in               load init_nodes_in/init_velocities_in (IDLE only)
//   init_nodes_in               initial positions, [0]=x, [1]=y, per node
//   init_velocities_in          initial velocities, same layout
//   frame_tick_in               start-of-frame pulse
//   node_in_x/_y/_valid/_done   streamed updated positions from the stage
//   velocity_in_x/_y/_valid     streamed updated velocities from the stage
//   result_in                   stage reports the step complete
//   begin_out                   one-cycle step start pulse
//   nodes_out, velocities_out   committed state
//   busy_out                    high whenever the FSM is not IDLE
//   frame_done_out              one-cycle pulse after the last step commits
//   step_count_out              steps committed in the current frame
//   error_out                   sticky: [0] count mismatch, [1] timeout,
//                               [2] frame tick while busy
//   state_dbg                   current FSM state, for observation only
//
// Stream handshake: the stream inputs are valid-only (no ready/backpressure).
// A sample is consumed on every clock edge where its valid is high and the
// FSM is in the matching capture state (NODES for positions, VELS for
// velocities); in any other state it is dropped. node_in_done and result_in
// are qualified the same way and a valid coincident with them is counted
// before the final count is checked.

module wheel_state_buffer #(
    parameter int NUM_NODES       = 8,
    parameter int POSITION_SIZE   = 16,
    parameter int VELOCITY_SIZE   = 16,
    parameter int STEPS_PER_FRAME = 4,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic                                                  clk_in,
    input  logic                                                  rst_in,
    input  logic                                                  init_valid_in,
    input  logic signed [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]   init_nodes_in,
    input  logic signed [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]   init_velocities_in,
    input  logic                                                  frame_tick_in,
    input  logic signed [POSITION_SIZE-1:0]                       node_in_x,
    input  logic signed [POSITION_SIZE-1:0]                       node_in_y,
    input  logic                                                  node_in_valid,
    input  logic                                                  node_in_done,
    input  logic signed [VELOCITY_SIZE-1:0]                       velocity_in_x,
    input  logic signed [VELOCITY_SIZE-1:0]                       velocity_in_y,
    input  logic                                                  velocity_in_valid,
    input  logic                                                  result_in,
    output logic                                                  begin_out,
    output logic signed [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]   nodes_out,
    output logic signed [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]   velocities_out,
    output logic                                                  busy_out,
    output logic                                                  frame_done_out,
    output logic [$clog2(STEPS_PER_FRAME):0]                      step_count_out,
    output logic [2:0]                                            error_out,
    output logic [2:0]                                            state_dbg
);

    localparam int SCW = $clog2(STEPS_PER_FRAME) + 1;
    localparam int NCW = $clog2(NUM_NODES + 1);
    localparam int NIW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
    // One spare count of headroom so the timer cannot wrap before the compare.
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 2);

    localparam logic [NCW-1:0] N_FULL  = NCW'(NUM_NODES);
    localparam logic [TCW-1:0] T_LIMIT = TCW'(TIMEOUT_CYCLES);
    localparam logic [SCW-1:0] S_LAST  = SCW'(STEPS_PER_FRAME);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        NODES  = 3'd2,
        VELS   = 3'd3,
        COMMIT = 3'd4
    } state_t;

    state_t state;

    logic signed [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0] shadow_pos;
    logic signed [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0] shadow_vel;

    logic [NCW-1:0] node_cnt;
    logic [NCW-1:0] vel_cnt;
    logic [TCW-1:0] timer;
    logic [SCW-1:0] step_count;

    logic           node_take;
    logic           vel_take;
    logic [NCW-1:0] node_total;
    logic [NCW-1:0] vel_total;
    logic [TCW-1:0] timer_next;
    logic           timer_hit;
    logic [NIW-1:0] node_idx;
    logic [NIW-1:0] vel_idx;

    assign busy_out       = (state != IDLE);
    assign step_count_out = step_count;
    assign state_dbg      = state;

    // Counts including a valid that coincides with done/result, so the final
    // count check sees the sample arriving in the same cycle.
    always_comb begin
        node_take  = node_in_valid && (node_cnt < N_FULL);
        vel_take   = velocity_in_valid && (vel_cnt < N_FULL);
        node_total = node_cnt + NCW'(node_take);
        vel_total  = vel_cnt + NCW'(vel_take);
        timer_next = timer + TCW'(1);
        timer_hit  = (timer_next >= T_LIMIT);
        node_idx   = node_cnt[NIW-1:0];
        vel_idx    = vel_cnt[NIW-1:0];
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state          <= IDLE;
            nodes_out      <= '0;
            velocities_out <= '0;
            shadow_pos     <= '0;
            shadow_vel     <= '0;
            node_cnt       <= '0;
            vel_cnt        <= '0;
            timer          <= '0;
            step_count     <= '0;
            begin_out      <= 1'b0;
            frame_done_out <= 1'b0;
            error_out      <= 3'b000;
        end else begin
            begin_out      <= 1'b0;
            frame_done_out <= 1'b0;

            if (frame_tick_in && (state != IDLE)) begin
                error_out[2] <= 1'b1;
            end

            case (state)
                IDLE: begin
                    // Init wins over a simultaneous tick; the tick is dropped.
                    if (init_valid_in) begin
                        nodes_out      <= init_nodes_in;
                        velocities_out <= init_velocities_in;
                    end else if (frame_tick_in) begin
                        step_count <= '0;
                        begin_out  <= 1'b1;
                        state      <= LAUNCH;
                    end
                end

                LAUNCH: begin
                    node_cnt <= '0;
                    vel_cnt  <= '0;
                    timer    <= '0;
                    // Seed the shadow with the committed state so a node the
                    // stage never reports keeps its committed value, and any
                    // residue of an aborted step is discarded.
                    shadow_pos <= nodes_out;
                    shadow_vel <= velocities_out;
                    state      <= NODES;
                end

                NODES: begin
                    if (node_in_valid) begin
                        if (node_take) begin
                            shadow_pos[0][node_idx] <= node_in_x;
                            shadow_pos[1][node_idx] <= node_in_y;
                            node_cnt                <= node_total;
                        end else begin
                            error_out[0] <= 1'b1;
                        end
                    end
                    // A done arriving on the last allowed cycle is in time.
                    if (node_in_done) begin
                        if (node_total != N_FULL) begin
                            error_out[0] <= 1'b1;
                        end
                        timer <= timer_next;
                        state <= VELS;
                    end else if (timer_hit) begin
                        error_out[1] <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        timer <= timer_next;
                    end
                end

                VELS: begin
                    if (velocity_in_valid) begin
                        if (vel_take) begin
                            shadow_vel[0][vel_idx] <= velocity_in_x;
                            shadow_vel[1][vel_idx] <= velocity_in_y;
                            vel_cnt                <= vel_total;
                        end else begin
                            error_out[0] <= 1'b1;
                        end
                    end
                    // A result on the last allowed cycle is in time.
                    if (result_in) begin
                        if (vel_total == N_FULL) begin
                            state <= COMMIT;
                        end else begin
                            error_out[0] <= 1'b1;
                            state        <= IDLE;
                        end
                    end else if (timer_hit) begin
                        error_out[1] <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        timer <= timer_next;
                    end
                end

                COMMIT: begin
                    nodes_out      <= shadow_pos;
                    velocities_out <= shadow_vel;
                    step_count     <= step_count + SCW'(1);
                    if ((step_count + SCW'(1)) < S_LAST) begin
                        begin_out <= 1'b1;
                        state     <= LAUNCH;
                    end else begin
                        frame_done_out <= 1'b1;
                        state          <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wheel_state_buffer.sv
// tb_wheel_state_buffer
//
// Directed sequence of frames against wheel_state_buffer with randomized
// stream payloads. A reference model keeps the committed and per-step shadow
// state as plain arrays of 16-bit words and updates them from the rules of
// the block (shadow starts as a copy of the committed state, a step commits
// only with a full velocity stream, errors are sticky).

module tb_wheel_state_buffer;

    localparam int N    = 8;
    localparam int P    = 16;
    localparam int V    = 16;
    localparam int SPF  = 4;
    localparam int TMO  = 16;
    localparam int PW   = 2 * N * P;
    localparam int SCW  = $clog2(SPF) + 1;

    // ---------------- clock / reset ----------------
    logic clk_in;
    logic rst_in;

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // ---------------- DUT ----------------
    logic                                init_valid_in;
    logic signed [1:0][N-1:0][P-1:0]     init_nodes_in;
    logic signed [1:0][N-1:0][V-1:0]     init_velocities_in;
    logic                                frame_tick_in;
    logic signed [P-1:0]                 node_in_x;
    logic signed [P-1:0]                 node_in_y;
    logic                                node_in_valid;
    logic                                node_in_done;
    logic signed [V-1:0]                 velocity_in_x;
    logic signed [V-1:0]                 velocity_in_y;
    logic                                velocity_in_valid;
    logic                                result_in;
    logic                                begin_out;
    logic signed [1:0][N-1:0][P-1:0]     nodes_out;
    logic signed [1:0][N-1:0][V-1:0]     velocities_out;
    logic                                busy_out;
    logic                                frame_done_out;
    logic [SCW-1:0]                      step_count_out;
    logic [2:0]                          error_out;
    logic [2:0]                          state_dbg;

    wheel_state_buffer #(
        .NUM_NODES      (N),
        .POSITION_SIZE  (P),
        .VELOCITY_SIZE  (V),
        .STEPS_PER_FRAME(SPF),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .init_valid_in     (init_valid_in),
        .init_nodes_in     (init_nodes_in),
        .init_velocities_in(init_velocities_in),
        .frame_tick_in     (frame_tick_in),
        .node_in_x         (node_in_x),
        .node_in_y         (node_in_y),
        .node_in_valid     (node_in_valid),
        .node_in_done      (node_in_done),
        .velocity_in_x     (velocity_in_x),
        .velocity_in_y     (velocity_in_y),
        .velocity_in_valid (velocity_in_valid),
        .result_in         (result_in),
        .begin_out         (begin_out),
        .nodes_out         (nodes_out),
        .velocities_out    (velocities_out),
        .busy_out          (busy_out),
        .frame_done_out    (frame_done_out),
        .step_count_out    (step_count_out),
        .error_out         (error_out),
        .state_dbg         (state_dbg)
    );

    // ---------------- reference model / scoreboard ----------------
    logic [15:0]   m_pos [2][N];
    logic [15:0]   m_vel [2][N];
    logic [2:0]    m_err;
    int            m_steps;
    logic [PW-1:0] exp_q[$];

    int tests_run;
    int tests_failed;
    int n_begin;
    int n_done;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk_in) begin
        if (begin_out)      n_begin++;
        if (frame_done_out) n_done++;
    end

    function automatic logic [PW-1:0] pack_arr(input logic [15:0] a [2][N]);
        logic [PW-1:0] r;
        r = '0;
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < N; i++)
                r[(c * N + i) * 16 +: 16] = a[c][i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp_v);
        tests_run++;
        assert (obs === exp_v)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance to 1 time unit after the next rising edge; inputs driven after
    // this are sampled on the following edge, outputs read here are stable.
    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_tick();
        frame_tick_in = 1'b1;
        cyc();
        frame_tick_in = 1'b0;
        m_steps = 0;
        chk("tick_busy", PW'(busy_out), PW'(1));
        chk("tick_step_clear", PW'(step_count_out), PW'(0));
    endtask

    // Precondition: currently in the cycle where begin_out should be high.
    task automatic run_step(input int npos, input int nvel, input bit plus_one, input bit tick_vels);
        logic [15:0]   sh_pos [2][N];
        logic [15:0]   sh_vel [2][N];
        logic [PW-1:0] before_p;
        logic [PW-1:0] before_v;
        before_p = pack_arr(m_pos);
        before_v = pack_arr(m_vel);
        sh_pos = m_pos;
        sh_vel = m_vel;
        chk("begin_pulse", PW'(begin_out), PW'(1));
        cyc();
        chk("begin_one_cycle", PW'(begin_out), PW'(0));

        if (npos == 0) begin
            node_in_done = 1'b1;
            cyc();
        end
        for (int i = 0; i < npos; i++) begin
            logic [15:0] vx;
            logic [15:0] vy;
            vx = plus_one ? (m_pos[0][i] + 16'd1) : 16'($urandom_range(0, 65535));
            vy = plus_one ? m_pos[1][i] : 16'($urandom_range(0, 65535));
            node_in_x     = vx;
            node_in_y     = vy;
            node_in_valid = 1'b1;
            node_in_done  = (i == npos - 1);
            if (i < N) begin
                sh_pos[0][i] = vx;
                sh_pos[1][i] = vy;
            end
            cyc();
        end
        node_in_valid = 1'b0;
        node_in_done  = 1'b0;
        if (npos != N) m_err[0] = 1'b1;
        chk("nodes_hold_mid_step", nodes_out, before_p);

        if (nvel == 0) begin
            result_in = 1'b1;
            cyc();
        end
        for (int j = 0; j < nvel; j++) begin
            logic [15:0] wx;
            logic [15:0] wy;
            wx = 16'($urandom_range(0, 65535));
            wy = 16'($urandom_range(0, 65535));
            velocity_in_x     = wx;
            velocity_in_y     = wy;
            velocity_in_valid = 1'b1;
            result_in         = (j == nvel - 1);
            frame_tick_in     = tick_vels && (j == 0);
            if (tick_vels && (j == 0)) m_err[2] = 1'b1;
            if (j < N) begin
                sh_vel[0][j] = wx;
                sh_vel[1][j] = wy;
            end
            cyc();
            frame_tick_in = 1'b0;
        end
        velocity_in_valid = 1'b0;
        result_in         = 1'b0;

        if (nvel == N) begin
            m_pos = sh_pos;
            m_vel = sh_vel;
            m_steps++;
            exp_q.push_back(pack_arr(sh_pos));
            chk("err_after_step", PW'(error_out), PW'(m_err));
            chk("pre_commit_hold", nodes_out, before_p);
            cyc();
            chk("commit_pos", nodes_out, exp_q.pop_front());
            chk("commit_vel", velocities_out, pack_arr(m_vel));
            chk("step_count", PW'(step_count_out), PW'(m_steps));
            if (m_steps < SPF) begin
                chk("relaunch", PW'(begin_out), PW'(1));
                chk("no_frame_done", PW'(frame_done_out), PW'(0));
            end else begin
                chk("frame_done", PW'(frame_done_out), PW'(1));
                chk("no_begin_at_end", PW'(begin_out), PW'(0));
                chk("idle_after_frame", PW'(busy_out), PW'(0));
            end
        end else begin
            m_err[0] = 1'b1;
            chk("abort_idle", PW'(busy_out), PW'(0));
            chk("abort_err", PW'(error_out), PW'(m_err));
            chk("abort_pos_hold", nodes_out, before_p);
            chk("abort_vel_hold", velocities_out, before_v);
            cyc();
            chk("abort_no_done", PW'(frame_done_out), PW'(0));
            chk("abort_no_begin", PW'(begin_out), PW'(0));
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [15:0]   fin [2][N];
        logic [PW-1:0] hold_p;
        int            nb0;
        int            nd0;

        tests_run          = 0;
        tests_failed       = 0;
        n_begin            = 0;
        n_done             = 0;
        rst_in             = 1'b1;
        init_valid_in      = 1'b0;
        init_nodes_in      = '0;
        init_velocities_in = '0;
        frame_tick_in      = 1'b0;
        node_in_x          = '0;
        node_in_y          = '0;
        node_in_valid      = 1'b0;
        node_in_done       = 1'b0;
        velocity_in_x      = '0;
        velocity_in_y      = '0;
        velocity_in_valid  = 1'b0;
        result_in          = 1'b0;
        m_err              = 3'b000;
        m_steps            = 0;

        cyc();
        cyc();
        chk("rst_nodes", nodes_out, '0);
        chk("rst_vels", velocities_out, '0);
        chk("rst_begin", PW'(begin_out), PW'(0));
        chk("rst_busy", PW'(busy_out), PW'(0));
        chk("rst_frame_done", PW'(frame_done_out), PW'(0));
        chk("rst_step_count", PW'(step_count_out), PW'(0));
        chk("rst_error", PW'(error_out), PW'(0));
        rst_in = 1'b0;
        cyc();

        // Init x=i*100, y=-i, random velocities; a coincident tick is dropped.
        for (int i = 0; i < N; i++) begin
            m_pos[0][i] = 16'(i * 100);
            m_pos[1][i] = 16'(-i);
            m_vel[0][i] = 16'($urandom_range(0, 65535));
            m_vel[1][i] = 16'($urandom_range(0, 65535));
        end
        init_nodes_in      = pack_arr(m_pos);
        init_velocities_in = pack_arr(m_vel);
        init_valid_in      = 1'b1;
        frame_tick_in      = 1'b1;
        cyc();
        init_valid_in = 1'b0;
        frame_tick_in = 1'b0;
        chk("init_nodes", nodes_out, pack_arr(m_pos));
        chk("init_vels", velocities_out, pack_arr(m_vel));
        chk("init_beats_tick", PW'(busy_out), PW'(0));
        chk("init_tick_no_err", PW'(error_out), PW'(0));
        cyc();
        chk("init_tick_no_begin", PW'(begin_out), PW'(0));

        // Frame 1: four clean steps, x advances by one per step.
        nb0 = n_begin;
        nd0 = n_done;
        do_tick();
        for (int s = 0; s < SPF; s++) run_step(N, N, 1'b1, 1'b0);
        for (int i = 0; i < N; i++) begin
            fin[0][i] = 16'(i * 100 + 4);
            fin[1][i] = 16'(-i);
        end
        chk("frame1_final_x", nodes_out, pack_arr(fin));
        chk("frame1_step_count", PW'(step_count_out), PW'(4));
        cyc();
        chk("frame1_begin_count", PW'(n_begin - nb0), PW'(SPF));
        chk("frame1_done_count", PW'(n_done - nd0), PW'(1));

        // Frame 2: short position stream still commits; short velocity
        // stream aborts the frame.
        nd0 = n_done;
        do_tick();
        run_step(N - 1, N, 1'b1, 1'b0);
        run_step(N, N - 1, 1'b0, 1'b0);
        chk("frame2_no_done", PW'(n_done - nd0), PW'(0));

        // Timeout: no stream after begin; an init attempt mid-step is ignored.
        hold_p = pack_arr(m_pos);
        do_tick();
        chk("tmo_begin", PW'(begin_out), PW'(1));
        cyc();
        init_nodes_in = ~pack_arr(m_pos);
        init_valid_in = 1'b1;
        cyc();
        init_valid_in = 1'b0;
        repeat (TMO - 2) cyc();
        chk("tmo_not_yet", PW'(error_out[1]), PW'(0));
        chk("tmo_busy_last", PW'(busy_out), PW'(1));
        cyc();
        m_err[1] = 1'b1;
        chk("tmo_error", PW'(error_out), PW'(m_err));
        chk("tmo_idle", PW'(busy_out), PW'(0));
        chk("tmo_nodes_hold", nodes_out, hold_p);

        // Frame 3: tick during VELS flags an overrun but the frame completes.
        nd0 = n_done;
        do_tick();
        run_step(N, N, 1'b0, 1'b1);
        for (int s = 1; s < SPF; s++) run_step(N, N, 1'b0, 1'b0);
        cyc();
        chk("frame3_done_count", PW'(n_done - nd0), PW'(1));
        chk("frame3_error", PW'(error_out), PW'(m_err));

        // Stream activity in IDLE is ignored.
        hold_p            = pack_arr(m_pos);
        node_in_valid     = 1'b1;
        node_in_done      = 1'b1;
        node_in_x         = 16'($urandom_range(0, 65535));
        velocity_in_valid = 1'b1;
        result_in         = 1'b1;
        repeat (3) cyc();
        node_in_valid     = 1'b0;
        node_in_done      = 1'b0;
        velocity_in_valid = 1'b0;
        result_in         = 1'b0;
        chk("idle_stream_pos", nodes_out, hold_p);
        chk("idle_stream_vel", velocities_out, pack_arr(m_vel));
        chk("idle_stream_busy", PW'(busy_out), PW'(0));

        // Asynchronous reset in the middle of NODES.
        do_tick();
        cyc();
        for (int i = 0; i < 3; i++) begin
            node_in_x     = 16'($urandom_range(0, 65535));
            node_in_y     = 16'($urandom_range(0, 65535));
            node_in_valid = 1'b1;
            cyc();
        end
        node_in_valid = 1'b0;
        chk("mid_busy_before_rst", PW'(busy_out), PW'(1));
        #2;
        rst_in = 1'b1;
        #1;
        chk("arst_nodes", nodes_out, '0);
        chk("arst_vels", velocities_out, '0);
        chk("arst_busy", PW'(busy_out), PW'(0));
        chk("arst_begin", PW'(begin_out), PW'(0));
        chk("arst_frame_done", PW'(frame_done_out), PW'(0));
        chk("arst_step_count", PW'(step_count_out), PW'(0));
        chk("arst_error", PW'(error_out), PW'(0));

        // ---------------- final report ----------------
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/wheel_state_buffer.md
Name: wheel_state_buffer

Overview:
Holds the committed soft-body wheel state (node positions and velocities) and drives the per-step begin pulse into the wheel physics update stage. It captures that stage's streamed node and velocity outputs into shadow arrays, and commits them only after the step's result strobe, so the arrays fed back as the next step's inputs stay stable mid-step. It runs STEPS_PER_FRAME physics steps per frame tick and then signals frame completion to the renderer.

Parameters:
NUM_NODES, 8, number of wheel nodes per step.
POSITION_SIZE, 16, signed position width.
VELOCITY_SIZE, 16, signed velocity width.
STEPS_PER_FRAME, 4, physics steps launched per frame_tick_in (≥1).
TIMEOUT_CYCLES, 4096, maximum cycles per step before abort.

Ports:
clk_in  input  1  clock
rst_in  input  1  asynchronous, active-high reset
init_valid_in  input  1  load initial state (honoured only in IDLE)
init_nodes_in  input  [1:0][NUM_NODES] x POSITION_SIZE signed  initial positions, x=[0], y=[1]
init_velocities_in  input  [1:0][NUM_NODES] x VELOCITY_SIZE signed  initial velocities
frame_tick_in  input  1  start-of-frame pulse
node_in_x, node_in_y  input  POSITION_SIZE signed  streamed updated position
node_in_valid  input  1  position sample valid
node_in_done  input  1  last position of step emitted
velocity_in_x, velocity_in_y  input  VELOCITY_SIZE signed  streamed updated velocity
velocity_in_valid  input  1  velocity sample valid
result_in  input  1  step complete
begin_out  output  1  one-cycle step start pulse to physics stage
nodes_out  output  [1:0][NUM_NODES] x POSITION_SIZE signed  committed positions
velocities_out  output  [1:0][NUM_NODES] x VELOCITY_SIZE signed  committed velocities
busy_out  output  1  high in any state other than IDLE
frame_done_out  output  1  one-cycle pulse after the last step of a frame commits
step_count_out  output  $clog2(STEPS_PER_FRAME)+1  steps committed this frame
error_out  output  3  sticky: [0] count mismatch, [1] timeout, [2] frame overrun

Behaviour:
- Reset (asynchronous, active-high): state IDLE; committed and shadow arrays zero; begin_out, frame_done_out, busy_out, step_count_out and error_out all 0.
- States: IDLE, LAUNCH, NODES, VELS, COMMIT.
- IDLE:
  - init_valid_in copies the init arrays into committed next edge; init_valid_in outside IDLE is ignored.
  - frame_tick_in clears step_count and goes to LAUNCH; init_valid_in takes priority if both assert in the same cycle (tick dropped, no error).
- LAUNCH: begin_out=1 for exactly this cycle; clear node/velocity counters and the timeout counter; go to NODES. A tick in IDLE at cycle t therefore gives begin_out at t+1.
- NODES:
  - Each node_in_valid writes shadow position[count] and increments the count.
  - Valids beyond NUM_NODES are discarded and set error[0].
  - When node_in_done arrives (its co-incident valid is captured first), go to VELS; if the final count ≠ NUM_NODES, set error[0].
- VELS:
  - Shadow velocities are captured the same way as positions in NODES.
  - result_in with velocity count = NUM_NODES goes to COMMIT.
  - result_in with velocity count ≠ NUM_NODES sets error[0], discards the shadow and returns to IDLE (frame aborted, no frame_done_out).
  - A velocity_in_valid that arrives in the same cycle as result_in is captured before the count is checked.
- COMMIT:
  - Copy shadow to committed in a single cycle and increment step_count.
  - If step_count+1 < STEPS_PER_FRAME, go to LAUNCH.
  - Otherwise pulse frame_done_out the next cycle and go to IDLE.
  - Result at t → commit at t+1 → begin_out or frame_done_out at t+2.
- nodes_out and velocities_out change only on a commit or an init load, never during NODES/VELS.
- Timeout: in NODES/VELS, a counter increments every cycle. Reaching TIMEOUT_CYCLES sets error[1], discards the shadow and returns to IDLE.
- frame_tick_in while busy_out=1 is dropped and sets error[2].
- error_out clears only on reset.
- Reset mid-step returns to IDLE immediately; the committed state is zeroed.
- Stream inputs arriving in IDLE, LAUNCH or COMMIT are ignored.

Test Plan:
- Reset, init NUM_NODES=8 nodes x=i*100, y=-i, then frame_tick → begin_out exactly one cycle after tick; nodes_out unchanged until result_in.
- Model streams 8 positions (x+1), done, 8 velocities, result; STEPS_PER_FRAME=4 → 4 begin pulses, each 2 cycles after result; frame_done_out once; step_count_out=4; final nodes_out x=i*100+4.
- Stream only 7 positions then node_in_done → error_out[0]=1; result with 8 velocities still commits.
- Stream 7 velocities then result → error_out[0]=1, no commit, IDLE, no frame_done_out.
- No stream after begin_out, TIMEOUT_CYCLES=16 → error_out[1]=1 at cycle 16 in NODES, busy_out=0 next cycle, nodes_out unchanged.
- frame_tick during VELS → error_out[2]=1, frame completes normally; rst_in asserted mid-NODES → all outputs 0 asynchronously.
